// File: rtl/vector_load_store_unit.sv
// vector_load_store_unit: MEM-stage load/store unit. Serialises scalar and
// VEC_LEN-lane vector accesses into single-word req/ack memory transfers,
// with per-lane masking and a gathered wide load result.
// Optional feature macro: LSU_STRIDE_EN (programmable signed element stride).
module vector_load_store_unit #(
    parameter int WORD_W  = 32,
    parameter int VEC_LEN = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic                      op_vector,
    input  logic                      op_write,
    input  logic [VEC_LEN-1:0]        op_mask,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         stride,
    input  logic [VEC_LEN*WORD_W-1:0] op_wdata,
    output logic                      stall,
    output logic                      done,
    output logic [VEC_LEN*WORD_W-1:0] rd_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    input  logic [WORD_W-1:0]         mem_rdata,
    input  logic                      mem_ack
);
    localparam int IDX_W      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int BYTE_SHIFT = $clog2(WORD_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                      state, state_next;
    logic [ADDR_W-1:0]           base_q;
    logic                        write_q;
    logic                        vector_q;
    logic [VEC_LEN-1:0]          mask_q;
    logic [VEC_LEN*WORD_W-1:0]   wdata_q;
    logic [VEC_LEN*WORD_W-1:0]   gather_q, gather_next;
    logic [IDX_W-1:0]            idx, last_idx;
    logic                        lane_en;
    logic                        advance;
    logic [ADDR_W-1:0]           lane_off;

`ifdef LSU_STRIDE_EN
    logic [ADDR_W-1:0]           stride_q;
    logic [ADDR_W-1:0]           stride_bytes;

    // Element stride scaled to bytes; the shift keeps the sign modulo 2^ADDR_W.
    assign stride_bytes = stride_q << BYTE_SHIFT;
    assign lane_off     = ADDR_W'(idx) * stride_bytes;
`else
    logic                        unused_stride;

    // Contiguous lanes: the stride input is deliberately ignored in this build.
    assign unused_stride = ^stride;
    assign lane_off      = ADDR_W'(idx) << BYTE_SHIFT;
`endif

    assign last_idx = vector_q ? IDX_W'(VEC_LEN - 1) : '0;
    assign lane_en  = mask_q[idx];

    // Handshake and memory outputs decode registered state only (no op_* -> mem_* path).
    assign op_ready  = (state == S_IDLE);
    assign stall     = (op_valid && state == S_IDLE) || (state == S_BUSY);
    assign done      = (state == S_DONE);
    assign mem_req   = (state == S_BUSY) && lane_en;
    assign mem_we    = mem_req && write_q;
    assign mem_addr  = base_q + lane_off;
    assign mem_wdata = wdata_q[idx*WORD_W +: WORD_W];

    // Next-state decode, lane advance and load-data gathering.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_next  = state;
        gather_next = gather_q;
        advance     = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) state_next = S_BUSY;
            end
            S_BUSY: begin
                advance = !lane_en || mem_ack;
                if (advance && lane_en && !write_q)
                    gather_next[idx*WORD_W +: WORD_W] = mem_rdata;
                if (advance && idx == last_idx)
                    state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register, operation latches, lane index and result register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: datapath registers are reset as well so mem_addr/mem_wdata read 0 out of reset.
            state    <= S_IDLE;
            idx      <= '0;
            base_q   <= '0;
            write_q  <= 1'b0;
            vector_q <= 1'b0;
            mask_q   <= '0;
            wdata_q  <= '0;
            gather_q <= '0;
            rd_data  <= '0;
`ifdef LSU_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        base_q   <= base_addr;
                        write_q  <= op_write;
                        vector_q <= op_vector;
                        mask_q   <= op_vector ? op_mask : VEC_LEN'(1);
                        wdata_q  <= op_wdata;
                        idx      <= '0;
                        gather_q <= '0;
`ifdef LSU_STRIDE_EN
                        stride_q <= stride;
`endif
                    end
                end
                S_BUSY: begin
                    gather_q <= gather_next;
                    if (advance && idx != last_idx)
                        idx <= idx + 1'b1;
                    // Result is captured on the way into DONE and held afterwards.
                    if (state_next == S_DONE)
                        rd_data <= write_q ? '0 : gather_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Self-checking bench for vector_load_store_unit: a driver issues operations and
// pushes expected memory requests, results and latencies into queues; a monitor
// with a small memory model answers requests and pops/compares on each event.
module tb_vector_load_store_unit;
    localparam int WORD_W  = 32;
    localparam int VEC_LEN = 4;
    localparam int ADDR_W  = 32;
    localparam int DW      = WORD_W * VEC_LEN;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic              op_vector = 1'b0;
    logic              op_write = 1'b0;
    logic [VEC_LEN-1:0] op_mask = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [DW-1:0]     op_wdata = '0;
    logic              stall;
    logic              done;
    logic [DW-1:0]     rd_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    vector_load_store_unit #(.WORD_W(WORD_W), .VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_vector(op_vector), .op_write(op_write), .op_mask(op_mask),
        .base_addr(base_addr), .stride(stride), .op_wdata(op_wdata),
        .stall(stall), .done(done), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [WORD_W-1:0] wdata;
    } req_t;

    req_t              exp_req[$];
    logic [DW-1:0]     exp_rd[$];
    int                exp_lat[$];
    logic [WORD_W-1:0] mem_model [logic [ADDR_W-1:0]];

    function automatic logic [WORD_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    int            cyc = 0;
    int            wait_states = 0;
    int            wait_cnt = 0;
    bit            stray_ack = 1'b0;
    int            accept_cyc = 0;
    int            done_count = 0;
    int            ops_issued = 0;
    int            last_done_cyc = 0;
    bit            b2b_check = 1'b0;
    bit            prev_done = 1'b0;
    logic [DW-1:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and memory model, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_req.delete();
            exp_rd.delete();
            exp_lat.delete();
            wait_cnt  = 0;
            mem_ack   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("rd_data_hold", rd_data, last_rd);
            prev_done = done;
            if (op_valid && op_ready) begin
                check("stall_at_accept", stall, 1);
                if (b2b_check) begin
                    check("b2b_accept_cycle", cyc, last_done_cyc + 1);
                    b2b_check = 1'b0;
                end
                accept_cyc = cyc;
            end
            if (done) begin
                done_count++;
                last_done_cyc = cyc;
                last_rd = rd_data;
                check("done_stall_low", stall, 0);
                check("done_op_ready_low", op_ready, 0);
                check("done_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    check("rd_data", rd_data, exp_rd.pop_front());
                    check("latency", cyc - accept_cyc, exp_lat.pop_front());
                end
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                check("busy_stall_high", stall, 1);
                check("busy_op_ready_low", op_ready, 0);
                if (wait_cnt >= wait_states) begin
                    mem_ack   = 1'b1;
                    wait_cnt  = 0;
                    mem_rdata = mem_read(mem_addr);
                    check("req_expected", exp_req.size() != 0, 1);
                    if (exp_req.size() != 0) begin
                        req_t r;
                        r = exp_req.pop_front();
                        check("mem_addr", mem_addr, r.addr);
                        check("mem_we", mem_we, r.we);
                        if (r.we) begin
                            check("mem_wdata", mem_wdata, r.wdata);
                            mem_model[mem_addr] = mem_wdata;
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Issue one operation: push expectations, then hold op_valid until accepted.
    task automatic issue(input bit vec, input bit we, input logic [VEC_LEN-1:0] mask,
                         input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride_v,
                         input logic [DW-1:0] wdata, input bit hold);
        logic [VEC_LEN-1:0] m;
        logic [DW-1:0]      rd;
        logic [ADDR_W-1:0]  a;
        req_t               r;
        int                 n;
        int                 lat;
        int                 t;
        m   = vec ? mask : VEC_LEN'(1);
        n   = vec ? VEC_LEN : 1;
        lat = 1;
        rd  = '0;
        for (int i = 0; i < n; i++) begin
`ifdef LSU_STRIDE_EN
            a = base + 32'(i) * stride_v * 4;
`else
            a = base + 32'(i) * 4;
`endif
            if (m[i]) begin
                lat += 1 + wait_states;
                r.addr  = a;
                r.we    = we;
                r.wdata = wdata[i*WORD_W +: WORD_W];
                exp_req.push_back(r);
                if (!we) rd[i*WORD_W +: WORD_W] = mem_read(a);
            end else begin
                lat += 1;
            end
        end
        exp_rd.push_back(we ? '0 : rd);
        exp_lat.push_back(lat);
        ops_issued++;
        op_vector = vec;
        op_write  = we;
        op_mask   = mask;
        base_addr = base;
        stride    = stride_v;
        op_wdata  = wdata;
        op_valid  = 1'b1;
        t = 0;
        while (!op_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", op_ready, 1);
        @(posedge clk); #1;
        if (!hold) op_valid = 1'b0;
    endtask

    // Wait (bounded) until every issued operation has produced its done pulse.
    task automatic wait_all();
        int t;
        t = 0;
        while (done_count < ops_issued && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_wait", done_count >= ops_issued, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int saved_done;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", op_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Scalar load, ack tied high.
        mem_model[32'h100] = 32'hDEADBEEF;
        wait_states = 0;
        issue(1'b0, 1'b0, 4'hF, 32'h100, 32'd0, '0, 1'b0);
        wait_all();
        check("scalar_rd_literal", rd_data, 128'hDEADBEEF);

        // Vector store, all lanes.
        issue(1'b1, 1'b1, 4'hF, 32'h200, 32'd1,
              {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        wait_all();
        check("store_rd_zero", rd_data, 0);
        check("store_lane3_mem", mem_read(32'h20C), 32'd4);

        // Masked load with one wait state per request and stray acks while idle.
        wait_states = 1;
        stray_ack   = 1'b1;
        issue(1'b1, 1'b0, 4'b1010, 32'h40, 32'd1, '0, 1'b0);
        wait_all();
        check("masked_latency_literal", last_done_cyc - accept_cyc, 7);
        stray_ack   = 1'b0;
        wait_states = 0;

        // Address wrap at the top of the address space.
        issue(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'd1, '0, 1'b0);
        wait_all();

`ifdef LSU_STRIDE_EN
        // Negative stride walks downward; zero stride broadcasts.
        issue(1'b1, 1'b0, 4'hF, 32'h1000, 32'hFFFF_FFFE, '0, 1'b0);
        wait_all();
        issue(1'b1, 1'b0, 4'hF, 32'h2000, 32'd0, '0, 1'b0);
        wait_all();
`endif

        // Scalar store ignores op_mask, then read back.
        issue(1'b0, 1'b1, 4'h0, 32'h300, 32'd1, {96'd0, 32'hCAFE_F00D}, 1'b0);
        wait_all();
        issue(1'b0, 1'b0, 4'h0, 32'h300, 32'd1, '0, 1'b0);
        wait_all();
        check("scalar_readback", rd_data, {96'd0, 32'hCAFE_F00D});

        // All-masked vector load: no requests, zero result.
        issue(1'b1, 1'b0, 4'h0, 32'h400, 32'd1, '0, 1'b0);
        wait_all();

        // Reset during lane 2 of a vector load.
        wait_states = 3;
        issue(1'b1, 1'b0, 4'hF, 32'h500, 32'd1, '0, 1'b0);
        t = 0;
        while (!(mem_req && mem_addr == 32'h508) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("reached_lane2", mem_req && mem_addr == 32'h508, 1);
        saved_done = done_count;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_op_ready", op_ready, 1);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_done", done, 0);
        reset = 1'b0;
        ops_issued = done_count;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_done", done_count, saved_done);
        wait_states = 0;
        issue(1'b0, 1'b0, 4'h0, 32'h600, 32'd1, '0, 1'b0);
        wait_all();

        // Back-to-back vector loads with op_valid held high.
        issue(1'b1, 1'b0, 4'hF, 32'h700, 32'd1, '0, 1'b1);
        b2b_check = 1'b1;
        issue(1'b1, 1'b0, 4'b0110, 32'h800, 32'd1, '0, 1'b0);
        wait_all();
        check("b2b_checked", b2b_check, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
